// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480 @ 60 Hz) and small helpers.
package vga_pkg;

    // Default horizontal timing, in pixels.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    // Default vertical timing, in lines.
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Width of the coordinate counters and of the frame counter.
    localparam int CNT_W   = 10;
    localparam int FRAME_W = 16;

    // One full period is the visible region plus the three blanking segments.
    function automatic int timing_total(input int active, input int fp,
                                        input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Per-pixel control bits that travel down the delay line together.
    typedef struct packed {
        logic hs;   // hsync at its output level
        logic vs;   // vsync at its output level
        logic vo;   // video_on for the same coordinate
    } vga_ctl_t;

    localparam int DEF_H_TOTAL = timing_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = timing_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register with a synchronous active-low clear.
// DEPTH = 0 degenerates to a plain wire.
module vga_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_ok;
        assign unused_ok = ^{clk_i, rst_n_i, en_i};
        assign q_o = d_i;
    end else begin : g_stages
        logic [WIDTH-1:0] stage_q [DEPTH];

        // Shift one stage per enabled tick; clear every stage on reset.
        // NOTE: only a handful of flops, so every stage is reset; a large RAM-style buffer would not be.
        always_ff @(posedge clk_i) begin
            if (!rst_n_i) begin
                for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
            end else if (en_i) begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, sync generation,
// a delay line matching the pixel generator latency, and registered outputs.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int IN_BITS    = 1,
    parameter int COLOR_BITS = 8,
    parameter int PIPE_LAT   = 1
) (
    input  logic                   clock_25,
    input  logic                   reset_key,
    input  logic                   pix_en,
    input  logic [3*IN_BITS-1:0]   rgb_in,
    output logic [CNT_W-1:0]       pixel_x,
    output logic [CNT_W-1:0]       pixel_y,
    output logic                   video_on,
    output logic                   line_start,
    output logic                   frame_start,
    output logic [FRAME_W-1:0]     frame_count,
    output logic                   vga_hs,
    output logic                   vga_vs,
    output logic                   vga_blank_n,
    output logic [COLOR_BITS-1:0]  vga_r,
    output logic [COLOR_BITS-1:0]  vga_g,
    output logic [COLOR_BITS-1:0]  vga_b
);

    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    // Idle state of the control bits: syncs deasserted, video off.
    localparam vga_ctl_t CTL_IDLE = '{hs: ~HS_POL, vs: ~VS_POL, vo: 1'b0};

    // Replicate a narrow channel MSB-first to fill the output width.
    function automatic logic [COLOR_BITS-1:0] expand(input logic [IN_BITS-1:0] c);
        logic [COLOR_BITS-1:0] res;
        res = '0;
        for (int i = 0; i < COLOR_BITS; i++) res[COLOR_BITS-1-i] = c[IN_BITS-1-(i % IN_BITS)];
        return res;
    endfunction

    logic [CNT_W-1:0]      h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0]      v_cnt_q, v_cnt_d;
    logic [FRAME_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic                  h_wrap, v_wrap;
    vga_ctl_t              ctl_raw, ctl_dly;
    logic                  hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
    logic [COLOR_BITS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

    // Counter next-state: h wraps at end of line, v steps on h wrap, frame on joint wrap.
    // NOTE: always_comb gets a default for every output first, so no path can infer a latch.
    always_comb begin
        h_wrap      = (h_cnt_q == H_LAST);
        v_wrap      = (v_cnt_q == V_LAST);
        h_cnt_d     = h_wrap ? '0 : h_cnt_q + 1'b1;
        v_cnt_d     = v_cnt_q;
        frame_cnt_d = frame_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
            if (v_wrap) frame_cnt_d = frame_cnt_q + 1'b1;
        end
    end

    // Counter registers, advancing only on pixel ticks.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock_25) begin
        if (!reset_key) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            frame_cnt_q <= '0;
        end else if (pix_en) begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Raw syncs and active-video flag decoded straight from the counters.
    always_comb begin
        ctl_raw    = CTL_IDLE;
        ctl_raw.vo = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        if ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ctl_raw.hs = HS_POL;
        if ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ctl_raw.vs = VS_POL;
    end

    // Align the control bits with the pixel generator's colour for the same coordinate.
    vga_delay_line #(
        .WIDTH     ($bits(vga_ctl_t)),
        .DEPTH     (PIPE_LAT),
        .RESET_VAL (CTL_IDLE)
    ) u_ctl_dly (
        .clk_i   (clock_25),
        .rst_n_i (reset_key),
        .en_i    (pix_en),
        .d_i     (ctl_raw),
        .q_o     (ctl_dly)
    );

    // Output next-state: colour passes only inside the (delayed) active area.
    always_comb begin
        hs_d      = ctl_dly.hs;
        vs_d      = ctl_dly.vs;
        blank_n_d = ctl_dly.vo;
        r_d       = '0;
        g_d       = '0;
        b_d       = '0;
        if (ctl_dly.vo) begin
            r_d = expand(rgb_in[3*IN_BITS-1 -: IN_BITS]);
            g_d = expand(rgb_in[2*IN_BITS-1 -: IN_BITS]);
            b_d = expand(rgb_in[IN_BITS-1 -: IN_BITS]);
        end
    end

    // Output register: syncs and colour update together on pixel ticks.
    always_ff @(posedge clock_25) begin
        if (!reset_key) begin
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            blank_n_q <= 1'b0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
        end else if (pix_en) begin
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
        end
    end

    assign pixel_x     = h_cnt_q;
    assign pixel_y     = v_cnt_q;
    assign video_on    = ctl_raw.vo;
    assign line_start  = (h_cnt_q == '0);
    assign frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign frame_count = frame_cnt_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a small 16x8 raster with a 2-tick pixel pipeline,
// plus a degenerate 1x1 raster instance used to reach the frame counter wrap.
module tb_vga_timing_gen;

    localparam int HT  = 16;
    localparam int VT  = 8;
    localparam int LAT = 3;   // PIPE_LAT + output register

    logic        clk;
    logic        rst_n;
    logic        pix_en;
    logic [2:0]  rgb_in;
    logic [9:0]  pixel_x, pixel_y;
    logic        video_on, line_start, frame_start;
    logic [15:0] frame_count;
    logic        vga_hs, vga_vs, vga_blank_n;
    logic [7:0]  vga_r, vga_g, vga_b;

    logic        rst2_n;
    logic [9:0]  px2, py2;
    logic        vo2, ls2, fs2, hs2, vs2, bn2;
    logic [15:0] fc2;
    logic [7:0]  r2, g2, b2;

    int          vectors = 0;
    int          miscompares = 0;
    int          n;                   // enabled ticks since reset release
    logic [2:0]  rgb_hist [4096];     // rgb_in presented on each enabled tick

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0),
        .IN_BITS(1), .COLOR_BITS(8), .PIPE_LAT(2)
    ) dut (
        .clock_25(clk), .reset_key(rst_n), .pix_en(pix_en), .rgb_in(rgb_in),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .line_start(line_start), .frame_start(frame_start), .frame_count(frame_count),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    // Every tick completes a frame here, so 65536 ticks exercise the wrap.
    vga_timing_gen #(
        .H_ACTIVE(1), .H_FP(0), .H_SYNC(0), .H_BP(0),
        .V_ACTIVE(1), .V_FP(0), .V_SYNC(0), .V_BP(0),
        .IN_BITS(1), .COLOR_BITS(8), .PIPE_LAT(0)
    ) dut_wrap (
        .clock_25(clk), .reset_key(rst2_n), .pix_en(1'b1), .rgb_in(3'b101),
        .pixel_x(px2), .pixel_y(py2), .video_on(vo2),
        .line_start(ls2), .frame_start(fs2), .frame_count(fc2),
        .vga_hs(hs2), .vga_vs(vs2), .vga_blank_n(bn2),
        .vga_r(r2), .vga_g(g2), .vga_b(b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at tick %0d: got 0x%0h expected 0x%0h", tag, n, got, exp);
        end
    endtask

    // Reference raster rules for enabled tick k since reset.
    function automatic int h_of(input int k); return k % HT;        endfunction
    function automatic int v_of(input int k); return (k / HT) % VT; endfunction
    function automatic bit vis(input int k);  return h_of(k) < 8 && v_of(k) < 4; endfunction
    function automatic bit hs_act(input int k); return h_of(k) >= 10 && h_of(k) <= 12; endfunction
    function automatic bit vs_act(input int k); return v_of(k) >= 5 && v_of(k) <= 6;   endfunction

    task automatic check_all();
        bit         vo_d;
        logic [2:0] c;
        check("pixel_x",     32'(pixel_x),     h_of(n));
        check("pixel_y",     32'(pixel_y),     v_of(n));
        check("video_on",    32'(video_on),    32'(vis(n)));
        check("line_start",  32'(line_start),  32'(h_of(n) == 0));
        check("frame_start", 32'(frame_start), 32'(h_of(n) == 0 && v_of(n) == 0));
        check("frame_count", 32'(frame_count), (n / (HT * VT)) % 65536);
        // Outputs show the coordinate LAT ticks back; earlier ticks show idle values.
        check("vga_hs",      32'(vga_hs),      32'((n >= LAT) ? !hs_act(n - LAT) : 1'b1));
        check("vga_vs",      32'(vga_vs),      32'((n >= LAT) ? !vs_act(n - LAT) : 1'b1));
        vo_d = (n >= LAT) && vis(n - LAT);
        check("vga_blank_n", 32'(vga_blank_n), 32'(vo_d));
        c = (vo_d && n >= 1) ? rgb_hist[n-1] : 3'b000;
        check("vga_r", 32'(vga_r), c[2] ? 32'hFF : 32'h00);
        check("vga_g", 32'(vga_g), c[1] ? 32'hFF : 32'h00);
        check("vga_b", 32'(vga_b), c[0] ? 32'hFF : 32'h00);
    endtask

    // One clock: drive at the falling edge, let the rising edge act, check at the next falling edge.
    task automatic step(input logic en, input logic [2:0] rgb);
        pix_en = en;
        rgb_in = rgb;
        @(posedge clk);
        if (en) begin
            rgb_hist[n] = rgb;
            n++;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic apply_reset(input int cycles);
        rst_n  = 1'b0;
        pix_en = 1'b0;
        rgb_in = 3'($urandom);
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        n = 0;
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        pix_en = 1'b0;
        rgb_in = 3'b000;
        n      = 0;
        @(negedge clk);
        apply_reset(2);

        // Continuous ticks, constant magenta: covers full frame and frame count 1.
        for (int i = 0; i < 200; i++) step(1'b1, 3'b101);

        // Alternating enable with random colour: holds must be exact.
        for (int i = 0; i < 300; i++) step(1'(i % 2 == 0), 3'($urandom));

        // Fully random enable and colour.
        for (int i = 0; i < 700; i++) step(1'($urandom_range(0, 1)), 3'($urandom));

        // Run to h=5, v=2 of a frame, then pulse reset with pix_en low.
        for (int i = 0; i < 2 * HT * VT && (n % (HT * VT)) != 2 * HT + 5; i++)
            step(1'b1, 3'($urandom));
        check("pre_reset_pos", 32'(n % (HT * VT)), 2 * HT + 5);
        apply_reset(1);
        for (int i = 0; i < 300; i++) step(1'b1, 3'($urandom));

        // Frame counter wrap on the 1x1 raster.
        rst_n  = 1'b0;
        rst2_n = 1'b1;
        repeat (65535) @(posedge clk);
        @(negedge clk);
        check("wrap_fc_ffff", 32'(fc2), 32'hFFFF);
        check("wrap_vga_r",   32'(r2),  32'hFF);
        check("wrap_vga_g",   32'(g2),  32'h00);
        @(posedge clk);
        @(negedge clk);
        check("wrap_fc_zero", 32'(fc2), 32'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameters H_FP/H_SYNC/H_BP, 16/96/48, horizontal front porch, sync and back porch in pixels; H_TOTAL is their sum with H_ACTIVE.
REQ-003 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-004 Parameters V_FP/V_SYNC/V_BP, 10/2/33, vertical front porch, sync and back porch in lines; V_TOTAL is their sum with V_ACTIVE.
REQ-005 Parameters HS_POL/VS_POL, 0/0, asserted sync level (0 = active-low).
REQ-006 Parameter IN_BITS, 1, bits per colour channel on rgb_in; COLOR_BITS, 8, bits per colour channel on outputs; IN_BITS ≤ COLOR_BITS.
REQ-007 Parameter PIPE_LAT, 1, pixel-generator latency in enabled ticks; range 0..8.
REQ-008 clock_25  input  1  pixel-domain clock; all logic on its rising edge.
REQ-009 reset_key  input  1  reset, synchronous, active-low.
REQ-010 pix_en  input  1  pixel tick; state advances only on cycles where it is 1.
REQ-011 rgb_in  input  3*IN_BITS  {R,G,B} from the pixel generator for the coordinate issued PIPE_LAT ticks earlier.
REQ-012 pixel_x, pixel_y  output  10 each  current counter coordinates.
REQ-013 video_on  output  1  current coordinate is inside the active area.
REQ-014 line_start, frame_start  output  1 each  high while pixel_x==0 (and pixel_y==0 for frame_start).
REQ-015 frame_count  output  16  completed frames, wraps modulo 2^16.
REQ-016 vga_hs, vga_vs, vga_blank_n  output  1 each  pipeline-aligned syncs and active-video flag.
REQ-017 vga_r, vga_g, vga_b  output  COLOR_BITS each  registered colour.

Function
REQ-018 h_cnt counts 0..H_TOTAL-1 on enabled ticks and wraps to 0; v_cnt increments when h_cnt wraps and itself wraps at V_TOTAL-1 → 0.
REQ-019 frame_count increments on the enabled tick where both counters wrap together.
REQ-020 pixel_x=h_cnt, pixel_y=v_cnt; video_on=(h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE), combinational from the counter registers, zero added latency.
REQ-021 Raw hsync is asserted for H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC; raw vsync for the analogous v_cnt window; asserted level = HS_POL/VS_POL.
REQ-022 Raw hsync, vsync and video_on pass through a PIPE_LAT-stage delay advancing only on enabled ticks, then one output register; total sync latency = PIPE_LAT+1 enabled ticks.
REQ-023 Colour output register loads, on an enabled tick, the expanded rgb_in when the delayed video_on is 1, else all zeros; colour and syncs change on the same clock edge.
REQ-024 Expansion: each channel is replicated MSB-first into COLOR_BITS (IN_BITS=1, bit 1 → 0xFF; IN_BITS=2, 2'b10 → 0xAA).
REQ-025 pix_en=0: every register holds, including the delay line and outputs.
REQ-026 PIPE_LAT=0: delay line is absent; only the output register remains.

Reset
REQ-027 reset_key=0 at a rising edge: h_cnt=v_cnt=0, frame_count=0, delay line and output syncs at deasserted level, vga_blank_n=0, colours=0, regardless of pix_en.
REQ-028 Reset mid-frame discards partial frame; first enabled tick after release presents coordinate (0,0) with frame_start=1.

Structure
REQ-029 Default 640x480 timing constants and the H_TOTAL/V_TOTAL derivation live in shared package vga_pkg.
REQ-030 Delay stages are one sub-module, vga_delay_line (parameters WIDTH, DEPTH; enable input; synchronous active-low clear).

Verification (small timing: H 8/2/3/3 = 16, V 4/1/2/1 = 8, PIPE_LAT=2, IN_BITS=1, pix_en=1)
REQ-031 Release reset, run 128 cycles → h_cnt wraps every 16, v_cnt every 128, frame_count=1 at cycle 128, frame_start high exactly at cycles 0 and 128.
REQ-032 Check hsync: raw active h_cnt 10..12; vga_hs low on cycles 13..15 of each line (latency 3); vga_vs low for lines 5..6 shifted by 3 cycles.
REQ-033 rgb_in=3'b101 constant → vga_r=0xFF, vga_g=0x00, vga_b=0xFF only while vga_blank_n=1; all zeros in blanking.
REQ-034 pix_en toggling 1,0,1,0 → counters, syncs and colour advance on every second cycle only; waveform identical to REQ-031 when sampled on enabled ticks.
REQ-035 Assert reset_key=0 at h=5, v=2 for one cycle → next cycle outputs match REQ-027 values, following enabled tick pixel_x=pixel_y=0, frame_count=0.
REQ-036 Wrap: preload to frame_count=0xFFFF via 65535 frames (or a force) → next frame completion gives 0x0000.
